// File: rtl/mat_pkg.sv
// Shared types and helpers for the matrix add/subtract engine.
package mat_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;

   // Clamp a signed value to the n_bits signed range; n_bits is an elaboration constant at every call site.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int n_bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (n_bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (n_bits - 1));
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

endpackage

// File: rtl/addsub_lane.sv
// One element of the datapath: sign-extend both operands, add or subtract, optionally clamp.
module addsub_lane #(
   parameter int N_BITS   = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic signed [N_BITS-1:0] a,
   input  logic signed [N_BITS-1:0] b,
   input  logic                     sub,
   output logic signed [N_BITS:0]   y
);
   import mat_pkg::*;

   logic signed [N_BITS:0] a_ext;
   logic signed [N_BITS:0] b_ext;
   logic signed [N_BITS:0] raw;

   // One extra bit makes the unsaturated result exact for any operand pair.
   always_comb begin
      a_ext = {a[N_BITS-1], a};
      b_ext = {b[N_BITS-1], b};
      raw   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
      y     = raw;
      if (SATURATE) y = (N_BITS+1)'(sat_signed(64'(raw), N_BITS));
   end

endmodule

// File: rtl/addsub_mat_seq.sv
// Sequential matrix add/subtract: LANES elements per cycle in row-major order,
// start/busy/done handshake, result held in a register array until the next accepted start.
module addsub_mat_seq #(
   parameter int SIZE_A   = 8,
   parameter int SIZE_B   = 8,
   parameter int N_BITS   = 32,
   parameter int LANES    = 2,
   parameter bit SATURATE = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic                     mode_sub,
   input  logic signed [N_BITS-1:0] mat_a   [SIZE_A][SIZE_B],
   input  logic signed [N_BITS-1:0] mat_b   [SIZE_A][SIZE_B],
   output logic                     busy,
   output logic                     done,
   output logic signed [N_BITS:0]   mat_out [SIZE_A][SIZE_B]
);
   import mat_pkg::*;

   localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
   localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SIZE_A - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(SIZE_B - LANES);

   generate
      if ((SIZE_B % LANES) != 0 || N_BITS > 63) begin : g_bad_params
         $error("addsub_mat_seq: LANES must divide SIZE_B and N_BITS must not exceed 63");
      end
   endgenerate

   addsub_state_t            state;
   addsub_state_t            state_nxt;
   logic [ROW_W-1:0]         row;
   logic [COL_W-1:0]         col;
   logic                     mode_q;
   logic                     last_chunk;
   logic                     accept;
   logic signed [N_BITS-1:0] a_chunk   [LANES];
   logic signed [N_BITS-1:0] b_chunk   [LANES];
   logic signed [N_BITS:0]   res_chunk [LANES];

   assign last_chunk = (row == LAST_ROW) && (col == LAST_COL);
   assign accept     = start && (state != RUN);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_chunk) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign a_chunk[l] = mat_a[row][col + COL_W'(l)];
         assign b_chunk[l] = mat_b[row][col + COL_W'(l)];

         addsub_lane #(.N_BITS(N_BITS), .SATURATE(SATURATE)) u_lane (
            .a   (a_chunk[l]),
            .b   (b_chunk[l]),
            .sub (mode_q),
            .y   (res_chunk[l])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= IDLE;
         row    <= '0;
         col    <= '0;
         mode_q <= 1'b0;
         // NOTE: the result array is cleared on reset because downstream stages can observe it.
         for (int r = 0; r < SIZE_A; r++)
            for (int c = 0; c < SIZE_B; c++)
               mat_out[r][c] <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            row    <= '0;
            col    <= '0;
            mode_q <= mode_sub;
         end else if (state == RUN) begin
            for (int k = 0; k < LANES; k++)
               mat_out[row][col + COL_W'(k)] <= res_chunk[k];
            if (col == LAST_COL) begin
               col <= '0;
               row <= row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(LANES);
            end
         end
      end
   end

endmodule

// File: tb/tb_addsub_mat_seq.sv
// Bench for addsub_mat_seq: directed small-matrix cases plus randomised 8x8 runs for every lane count.
module tb_addsub_mat_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic mode_sub;

   // Small 2x4 8-bit instances: index 0 unsaturated, index 1 saturated.
   logic signed [7:0]  sa    [2][4];
   logic signed [7:0]  sb    [2][4];
   logic               s_start [2];
   logic               s_busy  [2];
   logic               s_done  [2];
   logic signed [8:0]  s_out [2][2][4];

   // Large 8x8 32-bit instances, LANES = 1, 2, 4, 8.
   logic signed [31:0] ba    [8][8];
   logic signed [31:0] bb    [8][8];
   logic               b_start [4];
   logic               b_busy  [4];
   logic               b_done  [4];
   logic signed [32:0] b_out [4][8][8];

   int n_checks = 0;
   int n_fail   = 0;

   addsub_mat_seq #(.SIZE_A(2), .SIZE_B(4), .N_BITS(8), .LANES(2), .SATURATE(1'b0)) u_s0 (
      .clk(clk), .reset_n(reset_n), .start(s_start[0]), .mode_sub(mode_sub),
      .mat_a(sa), .mat_b(sb), .busy(s_busy[0]), .done(s_done[0]), .mat_out(s_out[0]));

   addsub_mat_seq #(.SIZE_A(2), .SIZE_B(4), .N_BITS(8), .LANES(2), .SATURATE(1'b1)) u_s1 (
      .clk(clk), .reset_n(reset_n), .start(s_start[1]), .mode_sub(mode_sub),
      .mat_a(sa), .mat_b(sb), .busy(s_busy[1]), .done(s_done[1]), .mat_out(s_out[1]));

   for (genvar g = 0; g < 4; g++) begin : g_big
      addsub_mat_seq #(.SIZE_A(8), .SIZE_B(8), .N_BITS(32), .LANES(1 << g), .SATURATE(1'b0)) u_dut (
         .clk(clk), .reset_n(reset_n), .start(b_start[g]), .mode_sub(mode_sub),
         .mat_a(ba), .mat_b(bb), .busy(b_busy[g]), .done(b_done[g]), .mat_out(b_out[g]));
   end

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: exact arithmetic on wide integers, then optional clamp to the nb-bit signed range.
   function automatic longint ref_elem(input longint a, input longint b, input bit sub,
                                       input bit sat, input int nb);
      longint v;
      longint hi;
      longint lo;
      v  = sub ? (a - b) : (a + b);
      hi = (longint'(1) << (nb - 1)) - 1;
      lo = -hi - 1;
      if (sat && v > hi) v = hi;
      if (sat && v < lo) v = lo;
      return v;
   endfunction

   function automatic int nz_small(input int idx);
      int n = 0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            if (s_out[idx][r][c] !== 9'sd0) n++;
      return n;
   endfunction

   function automatic int nz_big(input int g);
      int n = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            if (b_out[g][r][c] !== 33'sd0) n++;
      return n;
   endfunction

   task automatic rand_small();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin
            sa[r][c] = 8'($urandom);
            sb[r][c] = 8'($urandom);
         end
   endtask

   task automatic wait_small(input int idx, inout int edges);
      while (s_done[idx] !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
   endtask

   // Starts the instances selected by mask; edges counts from the accepting edge.
   task automatic run_small(input bit [1:0] mask, output int edges);
      @(negedge clk);
      s_start[0] = mask[0];
      s_start[1] = mask[1];
      @(negedge clk);
      s_start[0] = 1'b0;
      s_start[1] = 1'b0;
      edges = 1;
      wait_small(mask[0] ? 0 : 1, edges);
   endtask

   task automatic check_small(input int idx, input bit sat, input bit sub, input string tag);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            check($sformatf("%s[%0d][%0d]", tag, r, c), s_out[idx][r][c],
                  ref_elem(sa[r][c], sb[r][c], sub, sat, 8));
   endtask

   task automatic run_big(input int g, output int edges);
      @(negedge clk);
      b_start[g] = 1'b1;
      @(negedge clk);
      b_start[g] = 1'b0;
      edges = 1;
      while (b_done[g] !== 1'b1 && edges < 200) begin
         @(negedge clk);
         edges++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int edges;

      reset_n  = 1'b0;
      mode_sub = 1'b0;
      for (int i = 0; i < 2; i++) s_start[i] = 1'b0;
      for (int i = 0; i < 4; i++) b_start[i] = 1'b0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin
            sa[r][c] = '0;
            sb[r][c] = '0;
         end
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            ba[r][c] = '0;
            bb[r][c] = '0;
         end
      repeat (2) @(negedge clk);

      // Reset state of every instance.
      for (int i = 0; i < 2; i++) begin
         check($sformatf("rst_s%0d_busy", i), s_busy[i], 0);
         check($sformatf("rst_s%0d_done", i), s_done[i], 0);
         check($sformatf("rst_s%0d_nonzero", i), nz_small(i), 0);
      end
      for (int g = 0; g < 4; g++) begin
         check($sformatf("rst_b%0d_busy", g), b_busy[g], 0);
         check($sformatf("rst_b%0d_done", g), b_done[g], 0);
         check($sformatf("rst_b%0d_nonzero", g), nz_big(g), 0);
      end
      reset_n = 1'b1;

      // 1: A=1..8, B=1, subtract -> 0..7, done on the 5th edge.
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin
            sa[r][c] = 8'(r * 4 + c + 1);
            sb[r][c] = 8'sd1;
         end
      mode_sub = 1'b1;
      run_small(2'b01, edges);
      check("t1_latency", edges, 5);
      check("t1_done", s_done[0], 1);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            check($sformatf("t1_out[%0d][%0d]", r, c), s_out[0][r][c], r * 4 + c);
      @(negedge clk);
      check("t1_done_pulse", s_done[0], 0);
      check("t1_hold", s_out[0][1][3], 7);

      // 2: saturation corners on the unsaturated and saturated instances together.
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin
            sa[r][c] = 8'sd127;
            sb[r][c] = 8'sd127;
         end
      mode_sub = 1'b0;
      run_small(2'b11, edges);
      check("t2_latency", edges, 5);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("t2_nosat[1][%0d]", c), s_out[0][1][c], 254);
         check($sformatf("t2_sat[1][%0d]", c), s_out[1][1][c], 127);
      end
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) begin
            sa[r][c] = -8'sd128;
            sb[r][c] = 8'sd127;
         end
      mode_sub = 1'b1;
      run_small(2'b11, edges);
      check("t2b_latency", edges, 5);
      check("t2b_nosat", s_out[0][0][0], -255);
      check("t2b_sat_first", s_out[1][0][0], -128);
      check("t2b_sat_last", s_out[1][1][3], -128);

      // 3: start and mode flip during RUN are ignored.
      rand_small();
      mode_sub = 1'b0;
      @(negedge clk);
      s_start[0] = 1'b1;
      @(negedge clk);
      s_start[0] = 1'b0;
      edges = 1;
      @(negedge clk);
      edges++;
      mode_sub   = 1'b1;
      s_start[0] = 1'b1;
      @(negedge clk);
      edges++;
      s_start[0] = 1'b0;
      wait_small(0, edges);
      check("t3_latency", edges, 5);
      check_small(0, 1'b0, 1'b0, "t3_out");

      // 4: start during DONE restarts immediately.
      rand_small();
      mode_sub = 1'b1;
      run_small(2'b01, edges);
      check("t4a_latency", edges, 5);
      check_small(0, 1'b0, 1'b1, "t4a_out");
      rand_small();
      mode_sub   = 1'b0;
      s_start[0] = 1'b1;
      @(negedge clk);
      s_start[0] = 1'b0;
      check("t4_busy_no_idle", s_busy[0], 1);
      edges = 1;
      wait_small(0, edges);
      check("t4b_latency", edges, 5);
      check_small(0, 1'b0, 1'b0, "t4b_out");

      // 5: reset mid-run clears everything, then a fresh run completes.
      rand_small();
      mode_sub = 1'b0;
      @(negedge clk);
      s_start[0] = 1'b1;
      @(negedge clk);
      s_start[0] = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("t5_busy", s_busy[0], 0);
      check("t5_done", s_done[0], 0);
      check("t5_nonzero", nz_small(0), 0);
      reset_n = 1'b1;
      rand_small();
      mode_sub = 1'b1;
      run_small(2'b01, edges);
      check("t5_latency", edges, 5);
      check_small(0, 1'b0, 1'b1, "t5_out");

      // 6: randomised 8x8 for every lane count, both modes.
      for (int g = 0; g < 4; g++)
         for (int m = 0; m < 2; m++) begin
            for (int r = 0; r < 8; r++)
               for (int c = 0; c < 8; c++) begin
                  ba[r][c] = $urandom;
                  bb[r][c] = $urandom;
               end
            mode_sub = m[0];
            run_big(g, edges);
            check($sformatf("t6_l%0d_m%0d_latency", 1 << g, m), edges, 64 / (1 << g) + 1);
            for (int r = 0; r < 8; r++)
               for (int c = 0; c < 8; c++)
                  check($sformatf("t6_l%0d_m%0d[%0d][%0d]", 1 << g, m, r, c), b_out[g][r][c],
                        ref_elem(ba[r][c], bb[r][c], m[0], 1'b0, 32));
         end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
